// File: rtl/axi_rd_arbiter_pkg.sv
// Shared AXI read-arbiter definitions: response codes, widths and sizing helpers.
package axi_rd_arbiter_pkg;

  localparam int AXI_RESP_W = 2;

  localparam logic [AXI_RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [AXI_RESP_W-1:0] RESP_SLVERR = 2'b10;

  // Width of the timeout counter. A disabled timeout (0) still gets a
  // one-bit counter so no zero-width vectors appear anywhere.
  function automatic int cnt_width(input int timeout);
    if (timeout <= 0) begin
      return 1;
    end
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/axi_rd_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone requester wins outright, and on a tie
// the master that was not served last wins.
module axi_rd_arbiter_rr_pick2
  import axi_rd_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt
);

  // Pick the winner from the request pair and the last-served master.
  always_comb begin
    gnt = 1'b0;
    case (req)
      2'b01:   gnt = 1'b0;
      2'b10:   gnt = 1'b1;
      2'b11:   gnt = ~last;
      default: gnt = 1'b0;
    endcase
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI4-lite read port between M0 (instruction fetch) and M1 (load
// unit). One read is in flight at a time, grants alternate round-robin, and a
// slave that never answers is converted into an SLVERR for the waiting master.
//
// Handshake rule on every channel: a transfer happens on a rising clock edge
// where both valid and ready are high; a source holds valid and its payload
// stable until that edge, and ready may depend combinationally on valid.
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  // M0: instruction fetch
  input  logic [ADDR_W-1:0]     m0_araddr,
  input  logic                  m0_arvalid,
  output logic                  m0_arready,
  output logic [DATA_W-1:0]     m0_rdata,
  output logic [AXI_RESP_W-1:0] m0_rresp,
  output logic                  m0_rvalid,
  input  logic                  m0_rready,
  // M1: load unit
  input  logic [ADDR_W-1:0]     m1_araddr,
  input  logic                  m1_arvalid,
  output logic                  m1_arready,
  output logic [DATA_W-1:0]     m1_rdata,
  output logic [AXI_RESP_W-1:0] m1_rresp,
  output logic                  m1_rvalid,
  input  logic                  m1_rready,
  // Shared slave port
  output logic [ADDR_W-1:0]     s_araddr,
  output logic                  s_arvalid,
  input  logic                  s_arready,
  input  logic [DATA_W-1:0]     s_rdata,
  input  logic [AXI_RESP_W-1:0] s_rresp,
  input  logic                  s_rvalid,
  output logic                  s_rready,
  // Debug visibility of the arbiter state
  output logic [2:0]            dbg_state,
  output logic                  dbg_gnt,
  output logic                  dbg_last
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ADDR  = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_ERR   = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;

  localparam int               CNT_W   = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
  localparam bit               TO_EN   = (TIMEOUT != 0);

  logic [2:0]       state_q, state_d;
  logic             gnt_q, gnt_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             pick_gnt;
  logic             sel_arvalid;
  logic [ADDR_W-1:0] sel_araddr;
  logic             sel_rready;

  axi_rd_arbiter_rr_pick2 u_pick (
    .req  ({m1_arvalid, m0_arvalid}),
    .last (last_q),
    .gnt  (pick_gnt)
  );

  // Request/ready signals of whichever master currently holds the grant.
  always_comb begin
    sel_arvalid = gnt_q ? m1_arvalid : m0_arvalid;
    sel_araddr  = gnt_q ? m1_araddr  : m0_araddr;
    sel_rready  = gnt_q ? m1_rready  : m0_rready;
  end

  // Next-state logic: grant, address phase, data phase with timeout, error, drain.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (m0_arvalid || m1_arvalid) begin
          gnt_d   = pick_gnt;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        // An illegal arvalid drop simply leaves us waiting here.
        if (sel_arvalid && s_arready) begin
          state_d = ST_DATA;
          cnt_d   = '0;
        end
      end
      ST_DATA: begin
        if (s_rvalid && sel_rready) begin
          state_d = ST_IDLE;
          last_d  = gnt_q;
        end else if (!s_rvalid) begin
          if (TO_EN && (cnt_q == CNT_MAX)) begin
            state_d = ST_ERR;
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_ERR: begin
        if (sel_rready) begin
          state_d = ST_DRAIN;
          last_d  = gnt_q;
        end
      end
      ST_DRAIN: begin
        // Whatever the slave finally returns is swallowed here.
        if (s_rvalid) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output muxing purely from state and grant; the non-granted master sees zeros.
  always_comb begin
    m0_arready = 1'b0;
    m0_rdata   = '0;
    m0_rresp   = RESP_OKAY;
    m0_rvalid  = 1'b0;
    m1_arready = 1'b0;
    m1_rdata   = '0;
    m1_rresp   = RESP_OKAY;
    m1_rvalid  = 1'b0;
    s_araddr   = '0;
    s_arvalid  = 1'b0;
    s_rready   = 1'b0;
    case (state_q)
      ST_ADDR: begin
        s_araddr  = sel_araddr;
        s_arvalid = sel_arvalid;
        if (gnt_q) m1_arready = s_arready;
        else       m0_arready = s_arready;
      end
      ST_DATA: begin
        s_rready = sel_rready;
        if (gnt_q) begin
          m1_rdata  = s_rdata;
          m1_rresp  = s_rresp;
          m1_rvalid = s_rvalid;
        end else begin
          m0_rdata  = s_rdata;
          m0_rresp  = s_rresp;
          m0_rvalid = s_rvalid;
        end
      end
      ST_ERR: begin
        if (gnt_q) begin
          m1_rvalid = 1'b1;
          m1_rresp  = RESP_SLVERR;
        end else begin
          m0_rvalid = 1'b1;
          m0_rresp  = RESP_SLVERR;
        end
      end
      ST_DRAIN: begin
        s_rready = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Arbiter state registers; M0 wins the first tie after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Debug taps.
  always_comb begin
    dbg_state = state_q;
    dbg_gnt   = gnt_q;
    dbg_last  = last_q;
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: single read, round-robin ties, fairness
// under a continuously requesting load unit, slave timeout, drain of late data
// and reset in the middle of a transaction.
module tb_axi_rd_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_ERR   = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] m0_araddr, m1_araddr, s_araddr;
  logic          m0_arvalid, m1_arvalid, s_arvalid;
  logic          m0_arready, m1_arready, s_arready;
  logic [DW-1:0] m0_rdata, m1_rdata, s_rdata;
  logic [1:0]    m0_rresp, m1_rresp, s_rresp;
  logic          m0_rvalid, m1_rvalid, s_rvalid;
  logic          m0_rready, m1_rready, s_rready;
  logic [2:0]    dbg_state;
  logic          dbg_gnt, dbg_last;

  int n_tests = 0;
  int n_fail  = 0;

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  axi_rd_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .m0_araddr  (m0_araddr),
    .m0_arvalid (m0_arvalid),
    .m0_arready (m0_arready),
    .m0_rdata   (m0_rdata),
    .m0_rresp   (m0_rresp),
    .m0_rvalid  (m0_rvalid),
    .m0_rready  (m0_rready),
    .m1_araddr  (m1_araddr),
    .m1_arvalid (m1_arvalid),
    .m1_arready (m1_arready),
    .m1_rdata   (m1_rdata),
    .m1_rresp   (m1_rresp),
    .m1_rvalid  (m1_rvalid),
    .m1_rready  (m1_rready),
    .s_araddr   (s_araddr),
    .s_arvalid  (s_arvalid),
    .s_arready  (s_arready),
    .s_rdata    (s_rdata),
    .s_rresp    (s_rresp),
    .s_rvalid   (s_rvalid),
    .s_rready   (s_rready),
    .dbg_state  (dbg_state),
    .dbg_gnt    (dbg_gnt),
    .dbg_last   (dbg_last)
  );

  // Driver tasks
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    m0_araddr  = '0;
    m0_arvalid = 1'b0;
    m0_rready  = 1'b0;
    m1_araddr  = '0;
    m1_arvalid = 1'b0;
    m1_rready  = 1'b0;
    s_arready  = 1'b0;
    s_rdata    = '0;
    s_rresp    = 2'b00;
    s_rvalid   = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Runs one whole read with an always-ready slave, starting from IDLE or ADDR.
  // keep0/keep1: the master re-requests immediately after its address is taken.
  task automatic serve_one(input bit keep0, input bit keep1, input logic [DW-1:0] data,
                           output int g, output logic [DW-1:0] got, output bit ok);
    ok        = 1'b0;
    g         = -1;
    got       = '0;
    s_arready = 1'b1;
    m0_rready = 1'b1;
    m1_rready = 1'b1;
    for (int i = 0; i < 6 && dbg_state != S_ADDR; i++) tick();
    if (dbg_state == S_ADDR) begin
      g = int'(dbg_gnt);
      tick();
      if (g == 0 && !keep0) m0_arvalid = 1'b0;
      if (g == 1 && !keep1) m1_arvalid = 1'b0;
      s_rvalid = 1'b1;
      s_rdata  = data;
      s_rresp  = 2'b00;
      #1;
      got = (g == 0) ? m0_rdata : m1_rdata;
      ok  = (dbg_state == S_DATA);
      tick();
      s_rvalid = 1'b0;
      s_rdata  = '0;
      ok = ok && (dbg_state == S_IDLE);
    end
  endtask

  task automatic test_reset;
    do_reset();
    n_tests++;
    if ({dbg_state, dbg_gnt, dbg_last} !== {S_IDLE, 1'b0, 1'b1}) begin
      $display("FAIL reset_state: got state=%0d gnt=%0b last=%0b want state=0 gnt=0 last=1",
               dbg_state, dbg_gnt, dbg_last);
      n_fail++;
    end
    n_tests++;
    if ({m0_arready, m0_rvalid, m1_arready, m1_rvalid, s_arvalid, s_rready} !== 6'b0) begin
      $display("FAIL reset_handshakes: got %b want 000000",
               {m0_arready, m0_rvalid, m1_arready, m1_rvalid, s_arvalid, s_rready});
      n_fail++;
    end
    n_tests++;
    if ({m0_rdata, m1_rdata, m0_rresp, m1_rresp, s_araddr} !== '0) begin
      $display("FAIL reset_data: got m0_rdata=%h m1_rdata=%h m0_rresp=%b m1_rresp=%b s_araddr=%h want zeros",
               m0_rdata, m1_rdata, m0_rresp, m1_rresp, s_araddr);
      n_fail++;
    end
  endtask

  task automatic test_m0_single;
    do_reset();
    m0_araddr  = 32'h8000_0000;
    m0_arvalid = 1'b1;
    m0_rready  = 1'b1;
    s_arready  = 1'b1;
    #1;
    n_tests++;
    if ({dbg_state, s_arvalid, m0_arready} !== {S_IDLE, 1'b0, 1'b0}) begin
      $display("FAIL grant_latency: got state=%0d s_arvalid=%0b m0_arready=%0b want 0 0 0",
               dbg_state, s_arvalid, m0_arready);
      n_fail++;
    end
    tick();
    n_tests++;
    if ({dbg_state, dbg_gnt, s_arvalid, s_araddr, m0_arready, m1_arready} !==
        {S_ADDR, 1'b0, 1'b1, 32'h8000_0000, 1'b1, 1'b0}) begin
      $display("FAIL m0_addr_phase: got state=%0d gnt=%0b s_arvalid=%0b s_araddr=%h m0_arready=%0b m1_arready=%0b want 1 0 1 80000000 1 0",
               dbg_state, dbg_gnt, s_arvalid, s_araddr, m0_arready, m1_arready);
      n_fail++;
    end
    tick();
    m0_arvalid = 1'b0;
    s_rvalid   = 1'b1;
    s_rdata    = 32'h0000_0413;
    s_rresp    = 2'b00;
    #1;
    n_tests++;
    if ({m0_rvalid, m0_rdata, m0_rresp, s_rready} !== {1'b1, 32'h0000_0413, 2'b00, 1'b1}) begin
      $display("FAIL m0_data: got rvalid=%0b rdata=%h rresp=%b s_rready=%0b want 1 00000413 00 1",
               m0_rvalid, m0_rdata, m0_rresp, s_rready);
      n_fail++;
    end
    n_tests++;
    if ({m1_rvalid, m1_rdata, m1_rresp, m1_arready} !== '0) begin
      $display("FAIL m1_silent: got rvalid=%0b rdata=%h rresp=%b arready=%0b want zeros",
               m1_rvalid, m1_rdata, m1_rresp, m1_arready);
      n_fail++;
    end
    tick();
    s_rvalid = 1'b0;
    n_tests++;
    if ({dbg_state, dbg_last} !== {S_IDLE, 1'b0}) begin
      $display("FAIL m0_done: got state=%0d last=%0b want state=0 last=0", dbg_state, dbg_last);
      n_fail++;
    end
  endtask

  task automatic test_simultaneous;
    int            exp_g[3];
    int            g;
    logic [DW-1:0] got;
    bit            ok;
    exp_g = '{0, 1, 0};
    do_reset();
    m0_araddr  = 32'h0000_1000;
    m1_araddr  = 32'h0000_2000;
    m0_arvalid = 1'b1;
    m1_arvalid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      serve_one(1'b1, 1'b1, 32'hA000_0000 + DW'(k), g, got, ok);
      n_tests++;
      if (!ok || g != exp_g[k]) begin
        $display("FAIL tie_grant[%0d]: got gnt=%0d ok=%0b want gnt=%0d ok=1", k, g, ok, exp_g[k]);
        n_fail++;
      end
      n_tests++;
      if (dbg_last !== exp_g[k][0]) begin
        $display("FAIL tie_last[%0d]: got last=%0b want %0b", k, dbg_last, exp_g[k][0]);
        n_fail++;
      end
      n_tests++;
      if (got !== 32'hA000_0000 + DW'(k)) begin
        $display("FAIL tie_data[%0d]: got %h want %h", k, got, 32'hA000_0000 + DW'(k));
        n_fail++;
      end
    end
    m0_arvalid = 1'b0;
    m1_arvalid = 1'b0;
    tick();
  endtask

  task automatic test_fairness;
    int            g;
    logic [DW-1:0] got;
    bit            ok;
    do_reset();
    m1_araddr  = 32'h0000_3000;
    m1_arvalid = 1'b1;
    serve_one(1'b0, 1'b1, 32'h1111_1111, g, got, ok);
    n_tests++;
    if (!ok || g != 1) begin
      $display("FAIL fair_m1_first: got gnt=%0d ok=%0b want gnt=1 ok=1", g, ok);
      n_fail++;
    end
    tick();
    m0_araddr  = 32'h0000_4000;
    m0_arvalid = 1'b1;
    #1;
    n_tests++;
    if ({dbg_state, dbg_gnt, m0_arready, m1_arready} !== {S_ADDR, 1'b1, 1'b0, 1'b1}) begin
      $display("FAIL fair_m0_waits: got state=%0d gnt=%0b m0_arready=%0b m1_arready=%0b want 1 1 0 1",
               dbg_state, dbg_gnt, m0_arready, m1_arready);
      n_fail++;
    end
    serve_one(1'b0, 1'b1, 32'h2222_2222, g, got, ok);
    n_tests++;
    if (!ok || g != 1) begin
      $display("FAIL fair_m1_second: got gnt=%0d ok=%0b want gnt=1 ok=1", g, ok);
      n_fail++;
    end
    serve_one(1'b0, 1'b1, 32'h3333_3333, g, got, ok);
    n_tests++;
    if (!ok || g != 0 || got !== 32'h3333_3333) begin
      $display("FAIL fair_m0_next: got gnt=%0d data=%h ok=%0b want gnt=0 data=33333333 ok=1", g, got, ok);
      n_fail++;
    end
    serve_one(1'b0, 1'b1, 32'h4444_4444, g, got, ok);
    n_tests++;
    if (!ok || g != 1) begin
      $display("FAIL fair_m1_after: got gnt=%0d ok=%0b want gnt=1 ok=1", g, ok);
      n_fail++;
    end
    m1_arvalid = 1'b0;
    tick();
  endtask

  task automatic test_timeout;
    bit early;
    bit seen;
    do_reset();
    m0_araddr  = 32'h8000_0100;
    m0_arvalid = 1'b1;
    m0_rready  = 1'b0;
    s_arready  = 1'b1;
    tick();
    tick();
    m0_arvalid = 1'b0;
    early = 1'b0;
    for (int i = 0; i < TO; i++) begin
      if (m0_rvalid || dbg_state != S_DATA) early = 1'b1;
      tick();
    end
    n_tests++;
    if (early) begin
      $display("FAIL timeout_early: got response or state change within %0d DATA cycles want none", TO);
      n_fail++;
    end
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      if (m0_rvalid) seen = 1'b1;
      else tick();
    end
    n_tests++;
    if (!seen) begin
      $display("FAIL timeout_fire: got m0_rvalid=0 want 1 within 4 cycles after %0d DATA cycles", TO);
      n_fail++;
    end
    n_tests++;
    if ({m0_rresp, m0_rdata} !== {2'b10, 32'h0}) begin
      $display("FAIL timeout_slverr: got rresp=%b rdata=%h want 10 00000000", m0_rresp, m0_rdata);
      n_fail++;
    end
    n_tests++;
    if ({dbg_state, s_rready, m1_rvalid} !== {S_ERR, 1'b0, 1'b0}) begin
      $display("FAIL timeout_err_state: got state=%0d s_rready=%0b m1_rvalid=%0b want 3 0 0",
               dbg_state, s_rready, m1_rvalid);
      n_fail++;
    end
    tick();
    m0_rready = 1'b1;
    #1;
    n_tests++;
    if ({m0_rvalid, s_rready} !== 2'b10) begin
      $display("FAIL timeout_hold: got m0_rvalid=%0b s_rready=%0b want 1 0", m0_rvalid, s_rready);
      n_fail++;
    end
    tick();
    m0_rready = 1'b0;
    #1;
    n_tests++;
    if ({dbg_state, s_rready, m0_rvalid, dbg_last} !== {S_DRAIN, 1'b1, 1'b0, 1'b0}) begin
      $display("FAIL timeout_to_drain: got state=%0d s_rready=%0b m0_rvalid=%0b last=%0b want 4 1 0 0",
               dbg_state, s_rready, m0_rvalid, dbg_last);
      n_fail++;
    end
  endtask

  // Continues from the DRAIN state left by test_timeout.
  task automatic test_drain;
    m1_araddr  = 32'h0000_5000;
    m1_arvalid = 1'b1;
    m1_rready  = 1'b1;
    tick();
    n_tests++;
    if ({dbg_state, m1_arready, s_arvalid} !== {S_DRAIN, 1'b0, 1'b0}) begin
      $display("FAIL drain_no_grant: got state=%0d m1_arready=%0b s_arvalid=%0b want 4 0 0",
               dbg_state, m1_arready, s_arvalid);
      n_fail++;
    end
    s_rvalid = 1'b1;
    s_rdata  = 32'hDEAD_BEEF;
    s_rresp  = 2'b00;
    #1;
    n_tests++;
    if ({m0_rvalid, m1_rvalid, m0_rdata, m1_rdata} !== '0) begin
      $display("FAIL drain_discard: got m0_rvalid=%0b m1_rvalid=%0b m0_rdata=%h m1_rdata=%h want zeros",
               m0_rvalid, m1_rvalid, m0_rdata, m1_rdata);
      n_fail++;
    end
    tick();
    s_rvalid = 1'b0;
    s_rdata  = '0;
    n_tests++;
    if (dbg_state !== S_IDLE) begin
      $display("FAIL drain_to_idle: got state=%0d want 0", dbg_state);
      n_fail++;
    end
    tick();
    n_tests++;
    if ({dbg_state, dbg_gnt, s_arvalid, s_araddr} !== {S_ADDR, 1'b1, 1'b1, 32'h0000_5000}) begin
      $display("FAIL drain_waiting_req: got state=%0d gnt=%0b s_arvalid=%0b s_araddr=%h want 1 1 1 00005000",
               dbg_state, dbg_gnt, s_arvalid, s_araddr);
      n_fail++;
    end
    m1_arvalid = 1'b0;
    do_reset();
  endtask

  task automatic test_reset_mid;
    do_reset();
    m1_araddr  = 32'h0000_6000;
    m1_arvalid = 1'b1;
    m1_rready  = 1'b0;
    s_arready  = 1'b1;
    tick();
    tick();
    m1_arvalid = 1'b1;
    s_rvalid   = 1'b1;
    s_rdata    = 32'h0000_55AA;
    #1;
    n_tests++;
    if ({dbg_state, m1_rvalid, m1_rdata, s_rready} !== {S_DATA, 1'b1, 32'h0000_55AA, 1'b0}) begin
      $display("FAIL rstmid_setup: got state=%0d m1_rvalid=%0b m1_rdata=%h s_rready=%0b want 2 1 000055aa 0",
               dbg_state, m1_rvalid, m1_rdata, s_rready);
      n_fail++;
    end
    rst = 1'b1;
    tick();
    n_tests++;
    if ({dbg_state, dbg_gnt, dbg_last} !== {S_IDLE, 1'b0, 1'b1}) begin
      $display("FAIL rstmid_state: got state=%0d gnt=%0b last=%0b want 0 0 1", dbg_state, dbg_gnt, dbg_last);
      n_fail++;
    end
    n_tests++;
    if ({m0_arready, m0_rvalid, m1_arready, m1_rvalid, s_arvalid, s_rready, m1_rdata, s_araddr} !== '0) begin
      $display("FAIL rstmid_outputs: got hs=%b m1_rdata=%h s_araddr=%h want zeros",
               {m0_arready, m0_rvalid, m1_arready, m1_rvalid, s_arvalid, s_rready}, m1_rdata, s_araddr);
      n_fail++;
    end
    rst = 1'b0;
    clear_inputs();
    tick();
  endtask

  // Test sequence and final report
  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_m0_single();
    test_simultaneous();
    test_fairness();
    test_timeout();
    test_drain();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
